// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator running on the system clock with an internal pixel enable.
// All outputs are registered and decoded from next-state counter values so they share one edge.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned X_W      = 10,
   parameter int unsigned Y_W      = 10,
   parameter int unsigned FRAME_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic               pix_ce,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [X_W-1:0]     pix_x,
   output logic [Y_W-1:0]     pix_y,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam int unsigned HTotal   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VTotal   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HSyncBeg = H_ACTIVE + H_FP;
   localparam int unsigned HSyncEnd = HSyncBeg + H_SYNC;
   localparam int unsigned VSyncBeg = V_ACTIVE + V_FP;
   localparam int unsigned VSyncEnd = VSyncBeg + V_SYNC;
   localparam int unsigned DivW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
   localparam logic [X_W-1:0]  HLast   = X_W'(HTotal - 1);
   localparam logic [Y_W-1:0]  VLast   = Y_W'(VTotal - 1);

   if (CLK_DIV < 1) begin : g_div_chk
      $error("CLK_DIV must be at least 1");
   end
   if ((HTotal - 1) >= (2 ** X_W)) begin : g_xw_chk
      $error("X_W too narrow for horizontal total");
   end
   if ((VTotal - 1) >= (2 ** Y_W)) begin : g_yw_chk
      $error("Y_W too narrow for vertical total");
   end

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e               state_q, state_d;
   logic [DivW-1:0]      div_cnt_q, div_cnt_d;
   logic                 pix_ce_q, pix_ce_d;
   logic [X_W-1:0]       h_q, h_d;
   logic [Y_W-1:0]       v_q, v_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic                 hsync_q, hsync_d;
   logic                 vsync_q, vsync_d;
   logic                 de_q, de_d;
   logic [X_W-1:0]       pix_x_q, pix_x_d;
   logic [Y_W-1:0]       pix_y_q, pix_y_d;
   logic                 line_start_q, line_start_d;
   logic                 frame_start_q, frame_start_d;
   logic                 run;
   logic [31:0]          h_n, v_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         div_cnt_q     <= '0;
         pix_ce_q      <= 1'b0;
         h_q           <= '0;
         v_q           <= '0;
         frame_q       <= '0;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         de_q          <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_cnt_q     <= div_cnt_d;
         pix_ce_q      <= pix_ce_d;
         h_q           <= h_d;
         v_q           <= v_d;
         frame_q       <= frame_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   always_comb begin : p_next_state
      state_d = state_q;
      if (!en) begin
         state_d = StIdle;
      end else if (pix_ce_q) begin
         state_d = StRun;
      end
   end

   always_comb begin : p_counters
      div_cnt_d = (div_cnt_q == DivLast) ? '0 : div_cnt_q + DivW'(1);
      pix_ce_d  = en && (div_cnt_q == DivLast);
      h_d       = h_q;
      v_d       = v_q;
      frame_d   = frame_q;
      if (!en) begin
         div_cnt_d = '0;
         h_d       = '0;
         v_d       = '0;
         frame_d   = '0;
      end else if (pix_ce_q && (state_q == StRun)) begin
         if (h_q == HLast) begin
            h_d = '0;
            if (v_q == VLast) begin
               v_d     = '0;
               frame_d = frame_q + FRAME_W'(1);
            end else begin
               v_d = v_q + Y_W'(1);
            end
         end else begin
            h_d = h_q + X_W'(1);
         end
      end
   end

   // Decode from next counter values so every output lands on the same edge as the counters.
   always_comb begin : p_outputs
      run           = (state_d == StRun);
      h_n           = 32'(h_d);
      v_n           = 32'(v_d);
      de_d          = run && (h_n < H_ACTIVE) && (v_n < V_ACTIVE);
      pix_x_d       = de_d ? h_d : '0;
      pix_y_d       = de_d ? v_d : '0;
      hsync_d       = (run && (h_n >= HSyncBeg) && (h_n < HSyncEnd)) ? HS_POL : ~HS_POL;
      vsync_d       = (run && (v_n >= VSyncBeg) && (v_n < VSyncEnd)) ? VS_POL : ~VS_POL;
      line_start_d  = run && pix_ce_q && (h_d == '0);
      frame_start_d = line_start_d && (v_d == '0);
   end

   assign pix_ce      = pix_ce_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameter sets checked each cycle against an arithmetic model,
// plus hand tables for startup/line timing and sequences for enable drop and async reset.
module tb_vga_timing_gen;

   typedef struct packed {
      int cdiv; int ha; int hf; int hs; int hb; int va; int vf; int vs; int vb;
      bit hp; bit vp; int fw;
   } cfg_t;

   typedef struct packed {
      logic pce; logic hs; logic vs; logic de; logic ls; logic fs;
      logic [31:0] x; logic [31:0] y; logic [31:0] fc;
   } obs_t;

   typedef struct packed { int k; logic [4:0] flg; int x; int y; } vec_t;
   typedef struct packed { int k; logic hs; int fc; } svec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en_def = 1'b1, en_sm = 1'b1, en_mid = 1'b1;

   logic       pce0, hs0, vs0, de0, ls0, fs0;
   logic [9:0] x0, y0;
   logic [7:0] fc0;
   logic       pce1, hs1, vs1, de1, ls1, fs1;
   logic [9:0] x1, y1;
   logic [1:0] fc1;
   logic       pce2, hs2, vs2, de2, ls2, fs2;
   logic [4:0] x2;
   logic [3:0] y2;
   logic [2:0] fc2;

   int checks = 0, failures = 0;
   int k_def = 0, k_sm = 0, k_mid = 0, cyc = 0;
   cfg_t c_def, c_sm, c_mid;
   vec_t tbl[15];
   svec_t stbl[9];

   bit   meas = 1'b0;
   logic prev_hs0 = 1'b1, prev_hs1 = 1'b0;
   int   fall1 = -1, fall2 = -1, rise1 = -1, de_cnt = 0;
   int   sm_rise[6];
   int   n_sm_rise = 0;

   always #5 clk = ~clk;

   vga_timing_gen dut_def (
      .clk(clk), .rst(rst), .en(en_def), .pix_ce(pce0), .hsync(hs0), .vsync(vs0), .de(de0),
      .pix_x(x0), .pix_y(y0), .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .FRAME_W(2)
   ) dut_sm (
      .clk(clk), .rst(rst), .en(en_sm), .pix_ce(pce1), .hsync(hs1), .vsync(vs1), .de(de1),
      .pix_x(x1), .pix_y(y1), .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
   );

   vga_timing_gen #(
      .CLK_DIV(3), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .VS_POL(1'b1),
      .X_W(5), .Y_W(4), .FRAME_W(3)
   ) dut_mid (
      .clk(clk), .rst(rst), .en(en_mid), .pix_ce(pce2), .hsync(hs2), .vsync(vs2), .de(de2),
      .pix_x(x2), .pix_y(y2), .line_start(ls2), .frame_start(fs2), .frame_cnt(fc2)
   );

   // k = clock edges since release with en high; pixel t counts from the IDLE-to-RUN edge.
   function automatic obs_t model(input cfg_t c, input int k);
      obs_t e;
      int n, t, ht, vt, h, v, f;
      e = '0;
      e.hs = ~c.hp;
      e.vs = ~c.vp;
      if (k == 0) return e;
      e.pce = (k >= c.cdiv) && (k % c.cdiv == 0);
      n = (k - 1) / c.cdiv;
      if (n == 0) return e;
      t  = n - 1;
      ht = c.ha + c.hf + c.hs + c.hb;
      vt = c.va + c.vf + c.vs + c.vb;
      h  = t % ht;
      v  = (t / ht) % vt;
      f  = (t / (ht * vt)) % (1 << c.fw);
      e.de = (h < c.ha) && (v < c.va);
      e.x  = e.de ? 32'(h) : 32'd0;
      e.y  = e.de ? 32'(v) : 32'd0;
      if ((h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs)) e.hs = c.hp;
      if ((v >= c.va + c.vf) && (v < c.va + c.vf + c.vs)) e.vs = c.vp;
      e.ls = ((k - 1) % c.cdiv == 0) && (h == 0);
      e.fs = e.ls && (v == 0);
      e.fc = 32'(f);
      return e;
   endfunction

   task automatic cmp(input string nm, input int k, input obs_t exp, input obs_t act);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s k=%0d got pce=%0b hs=%0b vs=%0b de=%0b ls=%0b fs=%0b x=%0d y=%0d fc=%0d %s",
                  nm, k, act.pce, act.hs, act.vs, act.de, act.ls, act.fs, act.x, act.y, act.fc,
                  $sformatf("required pce=%0b hs=%0b vs=%0b de=%0b ls=%0b fs=%0b x=%0d y=%0d fc=%0d",
                            exp.pce, exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.x, exp.y, exp.fc));
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got %0d required %0d", nm, act, exp);
      end
   endtask

   task automatic check_all();
      cmp("def", k_def, model(c_def, k_def),
          {pce0, hs0, vs0, de0, ls0, fs0, 32'(x0), 32'(y0), 32'(fc0)});
      cmp("small", k_sm, model(c_sm, k_sm),
          {pce1, hs1, vs1, de1, ls1, fs1, 32'(x1), 32'(y1), 32'(fc1)});
      cmp("mid", k_mid, model(c_mid, k_mid),
          {pce2, hs2, vs2, de2, ls2, fs2, 32'(x2), 32'(y2), 32'(fc2)});
   endtask

   task automatic track();
      if (prev_hs0 && !hs0) begin
         if (fall1 < 0) fall1 = k_def;
         else if (fall2 < 0) fall2 = k_def;
      end
      if (!prev_hs0 && hs0 && fall1 >= 0 && rise1 < 0) rise1 = k_def;
      if (de0 && k_def <= 3204) de_cnt++;
      if (!prev_hs1 && hs1 && n_sm_rise < 6) begin
         sm_rise[n_sm_rise] = k_sm;
         n_sm_rise++;
      end
      for (int j = 0; j < 9; j++) begin
         if (k_sm == stbl[j].k) begin
            chk_int($sformatf("small_hs_k%0d", k_sm), 32'(hs1), 32'(stbl[j].hs));
            chk_int($sformatf("small_fc_k%0d", k_sm), 32'(fc1), stbl[j].fc);
         end
      end
      prev_hs0 = hs0;
      prev_hs1 = hs1;
   endtask

   task automatic step();
      @(posedge clk);
      k_def = (rst || !en_def) ? 0 : k_def + 1;
      k_sm  = (rst || !en_sm)  ? 0 : k_sm + 1;
      k_mid = (rst || !en_mid) ? 0 : k_mid + 1;
      @(negedge clk);
      cyc++;
      check_all();
      if (meas) track();
   endtask

   task automatic run_tbl(input int n);
      obs_t a, e;
      for (int i = 0; i < n; i++) begin
         int g = 0;
         while (k_def < tbl[i].k && g < 10000) begin
            step();
            g++;
         end
         chk_int($sformatf("tbl%0d_reach", i), k_def, tbl[i].k);
         e = '0;
         {e.pce, e.hs, e.de, e.ls, e.fs} = tbl[i].flg;
         e.vs = 1'b1;
         e.x  = 32'(tbl[i].x);
         e.y  = 32'(tbl[i].y);
         a = {pce0, hs0, vs0, de0, ls0, fs0, 32'(x0), 32'(y0), 32'(fc0)};
         cmp($sformatf("tbl%0d", i), k_def, e, a);
      end
   endtask

   function automatic vec_t mkv(input int k, input logic [4:0] flg, input int x, input int y);
      vec_t v;
      v.k = k; v.flg = flg; v.x = x; v.y = y;
      return v;
   endfunction

   function automatic svec_t mks(input int k, input logic hs, input int fc);
      svec_t v;
      v.k = k; v.hs = hs; v.fc = fc;
      return v;
   endfunction

   initial begin
      obs_t rdef, e;
      int lo_sm, lo_mid, g;
      c_def = '{cdiv:4, ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33,
                hp:1'b0, vp:1'b0, fw:8};
      c_sm  = '{cdiv:1, ha:4, hf:1, hs:2, hb:1, va:2, vf:1, vs:1, vb:1,
                hp:1'b1, vp:1'b0, fw:2};
      c_mid = '{cdiv:3, ha:10, hf:2, hs:3, hb:2, va:6, vf:1, vs:2, vb:1,
                hp:1'b0, vp:1'b1, fw:3};
      // Flags are {pce, hs, de, line_start, frame_start} for the default mode.
      tbl[0]  = mkv(1,    5'b01000, 0,   0);
      tbl[1]  = mkv(3,    5'b01000, 0,   0);
      tbl[2]  = mkv(4,    5'b11000, 0,   0);
      tbl[3]  = mkv(5,    5'b01111, 0,   0);
      tbl[4]  = mkv(6,    5'b01100, 0,   0);
      tbl[5]  = mkv(9,    5'b01100, 1,   0);
      tbl[6]  = mkv(2561, 5'b01100, 639, 0);
      tbl[7]  = mkv(2564, 5'b11100, 639, 0);
      tbl[8]  = mkv(2565, 5'b01000, 0,   0);
      tbl[9]  = mkv(2628, 5'b11000, 0,   0);
      tbl[10] = mkv(2629, 5'b00000, 0,   0);
      tbl[11] = mkv(3012, 5'b10000, 0,   0);
      tbl[12] = mkv(3013, 5'b01000, 0,   0);
      tbl[13] = mkv(3205, 5'b01110, 0,   1);
      tbl[14] = mkv(3206, 5'b01100, 0,   1);
      stbl[0] = mks(6,   1'b0, 0);
      stbl[1] = mks(7,   1'b1, 0);
      stbl[2] = mks(8,   1'b1, 0);
      stbl[3] = mks(9,   1'b0, 0);
      stbl[4] = mks(41,  1'b0, 0);
      stbl[5] = mks(42,  1'b0, 1);
      stbl[6] = mks(82,  1'b0, 2);
      stbl[7] = mks(122, 1'b0, 3);
      stbl[8] = mks(162, 1'b0, 0);
      rdef = '0;
      rdef.hs = 1'b1;
      rdef.vs = 1'b1;

      repeat (2) @(negedge clk);
      check_all();
      cmp("reset_def", 0, rdef, {pce0, hs0, vs0, de0, ls0, fs0, 32'(x0), 32'(y0), 32'(fc0)});
      rst = 1'b0;

      // Startup, line timing and small-mode frame sequence.
      meas = 1'b1;
      run_tbl(15);
      g = 0;
      while (k_def < 6100 && g < 10000) begin
         step();
         g++;
      end
      meas = 1'b0;
      chk_int("hs_first_fall", fall1, 2629);
      chk_int("hs_period", fall2 - fall1, 3200);
      chk_int("hs_low_width", rise1 - fall1, 384);
      chk_int("de_per_line", de_cnt, 2560);
      chk_int("small_rises", n_sm_rise, 6);
      for (int i = 1; i < 6; i++) chk_int("small_line_period", sm_rise[i] - sm_rise[i-1], 8);

      // Enable drop mid-line, then restart from (0,0).
      en_def = 1'b0;
      step();
      cmp("drop_def", k_def, rdef, {pce0, hs0, vs0, de0, ls0, fs0, 32'(x0), 32'(y0), 32'(fc0)});
      en_def = 1'b1;
      run_tbl(6);

      // Random enable drops on the small and mid instances.
      lo_sm = 0;
      lo_mid = 0;
      for (int i = 0; i < 6000; i++) begin
         if (lo_sm > 0) lo_sm--;
         else if ($urandom_range(0, 1999) == 0) lo_sm = $urandom_range(1, 4);
         if (lo_mid > 0) lo_mid--;
         else if ($urandom_range(0, 1999) == 0) lo_mid = $urandom_range(1, 4);
         en_sm  = (lo_sm == 0);
         en_mid = (lo_mid == 0);
         step();
      end
      en_sm  = 1'b1;
      en_mid = 1'b1;

      // Asynchronous reset while the default instance is inside horizontal sync.
      g = 0;
      e = model(c_def, k_def);
      while (e.hs != 1'b0 && g < 4000) begin
         step();
         e = model(c_def, k_def);
         g++;
      end
      chk_int("reach_hsync", 32'(hs0), 0);
      #3 rst = 1'b1;
      #1;
      k_def = 0;
      k_sm  = 0;
      k_mid = 0;
      check_all();
      cmp("async_def", 0, rdef, {pce0, hs0, vs0, de0, ls0, fs0, 32'(x0), 32'(y0), 32'(fc0)});
      @(posedge clk);
      @(negedge clk);
      check_all();
      rst = 1'b0;
      repeat (12) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
